// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: physical line/address and the
// physical-memory arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_pmem_addr;
    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } lc3b_arb_state;

    localparam int PMEM_ADDR_W = $bits(lc3b_pmem_addr);
    localparam int PMEM_LINE_W = $bits(lc3b_pmem_line);

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: first set request bit at or
// above rr_ptr, wrapping around to bit 0.
module arb_rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        int j;
        logic [IW-1:0] jj;
        j     = 0;
        jj    = '0;
        valid = |req;
        index = '0;
        // walk from the far end so the nearest hit is written last
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (req[jj]) index = jj;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port among
// NUM_CH line-read/line-write requesters.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
    input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic [LINE_W-1:0]          ch_rdata,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [ADDR_W-1:0]          pmem_address,
    output logic [LINE_W-1:0]          pmem_wdata,
    input  logic                       pmem_resp,
    input  logic [LINE_W-1:0]          pmem_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  grant_id
);

    localparam int IW = $clog2(NUM_CH);

    lc3b_arb_state state, state_next;

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gid;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic              complete;

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [LINE_W-1:0] wd_arr   [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_arr[i] = ch_address[i*ADDR_W +: ADDR_W];
        assign wd_arr[i]   = ch_wdata[i*LINE_W +: LINE_W];
    end

    arb_rr_picker #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_picker (
        .req    (ch_read | ch_write),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign complete = (state == ARB_BUSY) && pmem_resp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            gid       <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && pick_valid) begin
                gid       <= pick_idx;
                lat_wr    <= ch_write[pick_idx];
                lat_addr  <= addr_arr[pick_idx];
                lat_wdata <= wd_arr[pick_idx];
            end
            if (complete) begin
                rr_ptr <= (gid == IW'(NUM_CH - 1)) ? '0 : gid + IW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        ch_resp    = '0;
        ch_rdata   = '0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) state_next = ARB_BUSY;
            end
            ARB_BUSY: begin
                pmem_read  = !lat_wr;
                pmem_write = lat_wr;
                if (pmem_resp) begin
                    ch_resp[gid] = 1'b1;
                    ch_rdata     = pmem_rdata;
                    state_next   = ARB_DONE;
                end
            end
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    assign busy         = (state != ARB_IDLE);
    assign grant_id     = gid;
    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin reference model.
module tb_pmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      ch_read;
    logic [N-1:0]      ch_write;
    logic [N*AW-1:0]   ch_address;
    logic [N*LW-1:0]   ch_wdata;
    logic [N-1:0]      ch_resp;
    logic [LW-1:0]     ch_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [AW-1:0]     pmem_address;
    logic [LW-1:0]     pmem_wdata;
    logic              pmem_resp;
    logic [LW-1:0]     pmem_rdata;
    logic              busy;
    logic [1:0]        grant_id;

    logic [N-1:0]  rq_rd;
    logic [N-1:0]  rq_wr;
    logic [AW-1:0] a_addr [N];
    logic [LW-1:0] a_wd   [N];

    int checks;
    int failures;
    int m_rr;

    typedef struct {
        logic [1:0]    idle_op;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [1:0]    gid;
        logic          stable;
        logic [N-1:0]  early;
        logic [N-1:0]  resp;
        logic [LW-1:0] rdata;
        logic          done_busy;
        logic [1:0]    done_op;
        logic [N-1:0]  done_resp;
        logic          post_busy;
    } obs_t;

    assign ch_read  = rq_rd;
    assign ch_write = rq_wr;
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign ch_address[i*AW +: AW] = a_addr[i];
        assign ch_wdata[i*LW +: LW]   = a_wd[i];
    end

    pmem_arbiter #(
        .NUM_CH (N),
        .ADDR_W (AW),
        .LINE_W (LW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ch_read      (ch_read),
        .ch_write     (ch_write),
        .ch_address   (ch_address),
        .ch_wdata     (ch_wdata),
        .ch_resp      (ch_resp),
        .ch_rdata     (ch_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] req, input int rr);
        for (int i = 0; i < N; i++) begin
            if (req[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    // Drives one transaction from the IDLE cycle through DONE and the
    // following IDLE cycle, recording what the DUT showed.
    task automatic serve(input int lat, input logic [LW-1:0] rv,
                         input bit scramble, output obs_t o);
        o.idle_op = {pmem_read, pmem_write};
        @(posedge clk); #1;
        o.rd     = pmem_read;
        o.wr     = pmem_write;
        o.addr   = pmem_address;
        o.wdata  = pmem_wdata;
        o.gid    = grant_id;
        o.stable = 1'b1;
        o.early  = ch_resp;
        for (int k = 0; k < lat; k++) begin
            if (scramble) begin
                rq_rd = '0;
                rq_wr = '0;
                for (int i = 0; i < N; i++) begin
                    a_addr[i] = AW'($urandom);
                    a_wd[i]   = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            @(posedge clk); #1;
            if ({pmem_read, pmem_write, pmem_address, pmem_wdata, grant_id}
                !== {o.rd, o.wr, o.addr, o.wdata, o.gid}) o.stable = 1'b0;
            o.early |= ch_resp;
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rv;
        #1;
        o.resp  = ch_resp;
        o.rdata = ch_rdata;
        @(posedge clk); #1;
        o.done_busy = busy;
        o.done_op   = {pmem_read, pmem_write};
        o.done_resp = ch_resp;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        @(posedge clk); #1;
        o.post_busy = busy;
    endtask

    task automatic clear_req();
        rq_rd = '0;
        rq_wr = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        clear_req();
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0;
            a_wd[i]   = '0;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            failures++;
            $display("FAIL reset_op got=%b exp=00", {pmem_read, pmem_write});
        end
        checks++;
        if ({grant_id, pmem_address} !== '0) begin
            failures++;
            $display("FAIL reset_gid_addr got=%h exp=0", {grant_id, pmem_address});
        end
        checks++;
        if ({ch_resp, ch_rdata, pmem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_resp_data got=%h exp=0", {ch_resp, pmem_wdata});
        end
        reset_n = 1'b1;
        m_rr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        obs_t o;
        int g;
        rq_rd = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            g = pick(rq_rd, m_rr);
            serve($urandom_range(0, 3), '1, 1'b0, o);
            checks++;
            if (o.gid !== 2'(g) || o.resp !== N'(1 << g)) begin
                failures++;
                $display("FAIL alt_grant t=%0d got=%0d/%b exp=%0d", t, o.gid, o.resp, g);
            end
            checks++;
            if (o.rd !== 1'b1 || o.idle_op !== 2'b00 || o.done_op !== 2'b00) begin
                failures++;
                $display("FAIL alt_gap t=%0d rd=%b idle=%b done=%b exp=1/00/00",
                         t, o.rd, o.idle_op, o.done_op);
            end
            m_rr = (g + 1) % N;
        end
        clear_req();
    endtask

    task automatic test_single_read();
        obs_t o;
        logic [LW-1:0] pat;
        pat = {16{8'hA5}};
        rq_rd = 4'b0001;
        a_addr[0] = 16'h1230;
        serve(3, pat, 1'b0, o);
        clear_req();
        checks++;
        if (o.rd !== 1'b1 || o.wr !== 1'b0 || o.addr !== 16'h1230) begin
            failures++;
            $display("FAIL rd_issue got=%b%b/%h exp=10/1230", o.rd, o.wr, o.addr);
        end
        checks++;
        if (o.resp !== 4'b0001 || o.rdata !== pat || o.early !== '0) begin
            failures++;
            $display("FAIL rd_resp got=%b/%h early=%b exp=0001/%h", o.resp, o.rdata, o.early, pat);
        end
        checks++;
        if (o.done_busy !== 1'b1 || o.done_resp !== '0 || o.post_busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_done busy=%b resp=%b post=%b exp=1/0000/0",
                     o.done_busy, o.done_resp, o.post_busy);
        end
        m_rr = 1;
    endtask

    task automatic test_rr_wrap();
        obs_t o;
        rq_rd = 4'b0100;
        serve(0, '0, 1'b0, o);
        m_rr = 3;
        rq_rd = 4'b0110;
        serve(1, '0, 1'b0, o);
        checks++;
        if (o.gid !== 2'd1) begin
            failures++;
            $display("FAIL rr_wrap got=%0d exp=1", o.gid);
        end
        m_rr = 2;
        rq_rd = 4'b1111;
        serve(0, '0, 1'b0, o);
        checks++;
        if (o.gid !== 2'd2) begin
            failures++;
            $display("FAIL rr_after_wrap got=%0d exp=2", o.gid);
        end
        m_rr = 3;
        clear_req();
    endtask

    task automatic test_write_hold();
        obs_t o;
        logic [LW-1:0] w;
        w = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        rq_wr = 4'b0001;
        a_addr[0] = 16'h0040;
        a_wd[0] = w;
        serve(3, '0, 1'b1, o);
        clear_req();
        checks++;
        if (o.wr !== 1'b1 || o.rd !== 1'b0 || o.addr !== 16'h0040 || o.wdata !== w) begin
            failures++;
            $display("FAIL wr_issue got=%b%b/%h/%h exp=01/0040/%h", o.rd, o.wr, o.addr, o.wdata, w);
        end
        checks++;
        if (o.stable !== 1'b1) begin
            failures++;
            $display("FAIL wr_stable got=%b exp=1", o.stable);
        end
        checks++;
        if (o.resp !== 4'b0001) begin
            failures++;
            $display("FAIL wr_drop_resp got=%b exp=0001", o.resp);
        end
        m_rr = 1;
    endtask

    task automatic test_both();
        obs_t o;
        rq_rd = 4'b0001;
        rq_wr = 4'b0001;
        serve(1, '0, 1'b0, o);
        clear_req();
        checks++;
        if ({o.rd, o.wr} !== 2'b01) begin
            failures++;
            $display("FAIL both_is_write got=%b%b exp=01", o.rd, o.wr);
        end
        m_rr = 1;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int bad;
        bad = 0;
        rq_rd = 4'b0100;
        a_addr[2] = 16'h7777;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b/%0d/%b exp=1/2/1", busy, grant_id, pmem_read);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, pmem_read, pmem_write, grant_id, pmem_address} !== '0) begin
            failures++;
            $display("FAIL mid_async got=%h exp=0",
                     {busy, pmem_read, pmem_write, grant_id, pmem_address});
        end
        clear_req();
        @(posedge clk); #1;
        reset_n = 1'b1;
        pmem_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ch_resp !== '0 || busy !== 1'b0) bad++;
        end
        pmem_resp = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_no_resp got=%0d bad cycles exp=0", bad);
        end
        m_rr = 0;
        rq_rd = 4'b1111;
        serve(0, '0, 1'b0, o);
        clear_req();
        checks++;
        if (o.gid !== 2'd0) begin
            failures++;
            $display("FAIL mid_next_grant got=%0d exp=0", o.gid);
        end
        m_rr = 1;
    endtask

    task automatic test_random();
        obs_t o;
        int g;
        logic [N-1:0] rq;
        logic exp_wr;
        logic [AW-1:0] exp_a;
        logic [LW-1:0] exp_w;
        logic [LW-1:0] rv;
        for (int t = 0; t < 30; t++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            rq_rd = rq & N'($urandom);
            rq_wr = (rq & ~rq_rd) | (rq & N'($urandom));
            for (int i = 0; i < N; i++) begin
                a_addr[i] = AW'($urandom);
                a_wd[i]   = {$urandom, $urandom, $urandom, $urandom};
            end
            g = pick(rq, m_rr);
            exp_wr = rq_wr[g];
            exp_a  = a_addr[g];
            exp_w  = a_wd[g];
            rv = {$urandom, $urandom, $urandom, $urandom};
            serve($urandom_range(0, 4), rv, 1'($urandom), o);
            clear_req();
            checks++;
            if (o.gid !== 2'(g) || {o.rd, o.wr} !== {!exp_wr, exp_wr}) begin
                failures++;
                $display("FAIL rand_grant t=%0d got=%0d/%b%b exp=%0d/%b%b",
                         t, o.gid, o.rd, o.wr, g, !exp_wr, exp_wr);
            end
            checks++;
            if (o.addr !== exp_a || o.wdata !== exp_w || o.stable !== 1'b1) begin
                failures++;
                $display("FAIL rand_latch t=%0d got=%h/%h/%b exp=%h/%h/1",
                         t, o.addr, o.wdata, o.stable, exp_a, exp_w);
            end
            checks++;
            if (o.resp !== N'(1 << g) || o.rdata !== rv || o.early !== '0) begin
                failures++;
                $display("FAIL rand_resp t=%0d got=%b/%h exp=%b/%h",
                         t, o.resp, o.rdata, N'(1 << g), rv);
            end
            checks++;
            if (o.done_op !== 2'b00 || o.done_resp !== '0 || o.post_busy !== 1'b0) begin
                failures++;
                $display("FAIL rand_done t=%0d op=%b resp=%b post=%b exp=00/0000/0",
                         t, o.done_op, o.done_resp, o.post_busy);
            end
            m_rr = (g + 1) % N;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_rr     = 0;
        test_reset();
        test_alternate();
        test_single_read();
        test_rr_wrap();
        test_write_hold();
        test_both();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
